// File: rtl/nes_joypad_regs.sv
// CPU-side joypad registers: pops button words from the sampler FIFO and serves $4016/$4017 strobe/serial reads.
// Optional auto-fire is compiled in with `define JOY_TURBO_EN (TURBO_PERIOD polls per half-period).
module nes_joypad_regs
`ifdef JOY_TURBO_EN
  #(parameter logic [7:0] TURBO_PERIOD = 8'd4)
`endif
(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_clock,
  input  logic        fifo_rdempty,
  output logic        fifo_rdreq,
  input  logic [15:0] fifo_q,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_en
);

  typedef enum logic [1:0] {IDLE, WAIT, CAP} fifo_state_t;

  fifo_state_t state, state_next;
  logic [15:0] snapshot;
  logic [15:0] reload;
  logic [7:0]  shift0, shift1;
  logic        strobe;
  logic        sel0, sel1, wr_strobe, rd0, rd1;
  logic        unused_din;

  assign unused_din = ^cpu_din[7:1];

  // FIFO pop sequencer: non-showahead, so q is only valid the cycle after rdreq
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_rdreq = 1'b0;
    case (state)
      IDLE: if (!fifo_rdempty) begin
        fifo_rdreq = 1'b1;
        state_next = WAIT;
      end
      WAIT:    state_next = CAP;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)             snapshot <= 16'h0000;
    else if (state == CAP)  snapshot <= ~fifo_q;
  end

  assign sel0      = (cpu_addr == 16'h4016);
  assign sel1      = (cpu_addr == 16'h4017);
  assign wr_strobe = cpu_clock & ~cpu_rw & sel0;
  assign rd0       = cpu_clock & cpu_rw & sel0;
  assign rd1       = cpu_clock & cpu_rw & sel1;

`ifdef JOY_TURBO_EN
  logic [7:0] turbo_cnt;
  logic       turbo_phase;

  // Phase flips on the poll after TURBO_PERIOD polls have been counted
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      turbo_cnt   <= 8'd0;
      turbo_phase <= 1'b0;
    end else if (wr_strobe && cpu_din[0]) begin
      if (turbo_cnt == TURBO_PERIOD) begin
        turbo_cnt   <= 8'd1;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 8'd1;
      end
    end
  end

  assign reload = turbo_phase ? snapshot : (snapshot & 16'h3F3F);
`else
  assign reload = snapshot;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)         strobe <= 1'b0;
    else if (wr_strobe) strobe <= cpu_din[0];
  end

  // Reload samples the pre-capture snapshot; serial shift fills with 1s
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      shift0 <= 8'h00;
      shift1 <= 8'h00;
    end else if (cpu_clock && strobe) begin
      shift0 <= reload[7:0];
      shift1 <= reload[15:8];
    end else begin
      if (rd0) shift0 <= {shift0[6:0], 1'b1};
      if (rd1) shift1 <= {shift1[6:0], 1'b1};
    end
  end

  // While strobe is high the A button is returned live
  always_comb begin
    cpu_dout    = 8'h40;
    cpu_dout_en = 1'b0;
    if (cpu_rw && sel0) begin
      cpu_dout_en = 1'b1;
      cpu_dout[0] = strobe ? reload[7] : shift0[7];
    end else if (cpu_rw && sel1) begin
      cpu_dout_en = 1'b1;
      cpu_dout[0] = strobe ? reload[15] : shift1[7];
    end
  end

endmodule

// File: tb/tb_nes_joypad_regs.sv
// Self-checking bench for nes_joypad_regs: FIFO model plus an abstract button-order reference model.
module tb_nes_joypad_regs;
`ifdef JOY_TURBO_EN
  localparam logic [7:0] TP = 8'd2;
`endif

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_clock = 1'b0;
  logic        fifo_rdempty = 1'b1;
  logic        fifo_rdreq;
  logic [15:0] fifo_q = 16'hFFFF;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_en;

  int errors = 0;
  int checks = 0;
  int w1_count = 0;
  int poll_w1 = 0;
  int cyc = 0;
  int empty_pops = 0;
  logic [15:0] fifo_mem[$];
  int pop_cycles[$];

`ifdef JOY_TURBO_EN
  nes_joypad_regs #(.TURBO_PERIOD(TP)) dut (
`else
  nes_joypad_regs dut (
`endif
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock),
    .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en));

  always #5 sysclk = ~sysclk;

  // Non-showahead FIFO read side
  always @(posedge sysclk) begin
    cyc = cyc + 1;
    if (fifo_rdreq) begin
      pop_cycles.push_back(cyc);
      if (fifo_mem.size() == 0) empty_pops = empty_pops + 1;
      else fifo_q <= fifo_mem.pop_front();
    end
  end

  always @(negedge sysclk) fifo_rdempty = (fifo_mem.size() == 0);

  // Expected byte for the k-th serial read since the last reload of a pad
  function automatic logic [7:0] exp_read(input logic [15:0] raw, input int pad, input int k, input int w1);
    logic [15:0] pressed;
    logic [7:0]  p;
    pressed = ~raw;
    p = (pad == 1) ? pressed[15:8] : pressed[7:0];
`ifdef JOY_TURBO_EN
    if (w1 == 0 || (((w1 - 1) / int'(TP)) % 2) == 0) p[7:6] = 2'b00;
`else
    if (w1 < 0) p = 8'h00;
`endif
    if (k >= 8) return 8'h41;
    return {7'h20, p[7 - k]};
  endfunction

  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           output logic [7:0] dout, output logic en);
    @(negedge sysclk);
    cpu_addr = a; cpu_rw = rw; cpu_din = d; cpu_clock = 1'b1;
    #1;
    dout = cpu_dout;
    en = cpu_dout_en;
    if (!rw && a == 16'h4016 && d[0]) w1_count = w1_count + 1;
    @(negedge sysclk);
    cpu_clock = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_din = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] v;
    logic e;
    bus_cycle(a, 1'b0, d, v, e);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    logic e;
    bus_cycle(a, 1'b1, 8'h00, v, e);
  endtask

  task automatic poll();
    bus_write(16'h4016, 8'h01);
    poll_w1 = w1_count;
    bus_write(16'h4016, 8'h00);
  endtask

  task automatic push_word(input logic [15:0] w);
    @(negedge sysclk);
    #2 fifo_mem.push_back(w);
  endtask

  task automatic settle();
    repeat (12) @(negedge sysclk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic e;
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++;
    if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b exp=0", fifo_rdreq); end
    reset = 1'b1;
    w1_count = 0;
    for (int i = 0; i < 2; i++) begin
      bus_cycle(16'h4016, 1'b1, 8'h00, v, e);
      checks++;
      if (v !== 8'h40 || e !== 1'b1) begin errors++; $display("FAIL reset_read%0d got=%h/%b exp=40/1", i, v, e); end
    end
    bus_cycle(16'h4000, 1'b1, 8'h00, v, e);
    checks++;
    if (v !== 8'h40 || e !== 1'b0) begin errors++; $display("FAIL other_addr got=%h/%b exp=40/0", v, e); end
    checks++;
    if (pop_cycles.size() != 0 || empty_pops != 0) begin
      errors++; $display("FAIL idle_rdreq pops=%0d exp=0", pop_cycles.size());
    end
  endtask

  task automatic test_serial();
    logic [7:0] v;
    push_word(16'hFF7E);
    settle();
    poll();
    for (int k = 0; k < 10; k++) begin
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(16'hFF7E, 0, k, poll_w1)) begin
        errors++; $display("FAIL serial_pad0 k=%0d got=%h exp=%h", k, v, exp_read(16'hFF7E, 0, k, poll_w1));
      end
    end
    for (int k = 0; k < 9; k++) begin
      bus_read(16'h4017, v);
      checks++;
      if (v !== exp_read(16'hFF7E, 1, k, poll_w1)) begin
        errors++; $display("FAIL serial_pad1 k=%0d got=%h exp=%h", k, v, exp_read(16'hFF7E, 1, k, poll_w1));
      end
    end
  endtask

  task automatic test_strobe_held();
    logic [7:0] v;
    push_word(16'hFF7F);
    settle();
    bus_write(16'h4016, 8'h01);
    poll_w1 = w1_count;
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(16'hFF7F, 0, 0, poll_w1)) begin
        errors++; $display("FAIL strobe_held i=%0d got=%h exp=%h", i, v, exp_read(16'hFF7F, 0, 0, poll_w1));
      end
    end
    bus_write(16'h4017, 8'h00);
    for (int i = 0; i < 2; i++) begin
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(16'hFF7F, 0, 0, poll_w1)) begin
        errors++; $display("FAIL w4017_ignored i=%0d got=%h exp=%h", i, v, exp_read(16'hFF7F, 0, 0, poll_w1));
      end
    end
    bus_write(16'h4016, 8'h00);
    for (int k = 0; k < 2; k++) begin
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(16'hFF7F, 0, k, poll_w1)) begin
        errors++; $display("FAIL strobe_release k=%0d got=%h exp=%h", k, v, exp_read(16'hFF7F, 0, k, poll_w1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [15:0] w1, w2;
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    pop_cycles.delete();
    @(negedge sysclk);
    #2;
    fifo_mem.push_back(w1);
    fifo_mem.push_back(w2);
    settle();
    checks++;
    if (pop_cycles.size() != 2) begin
      errors++; $display("FAIL b2b_pops got=%0d exp=2", pop_cycles.size());
    end else begin
      checks++;
      if (pop_cycles[1] - pop_cycles[0] < 3) begin
        errors++; $display("FAIL b2b_spacing got=%0d exp>=3", pop_cycles[1] - pop_cycles[0]);
      end
    end
    checks++;
    if (empty_pops != 0) begin errors++; $display("FAIL rdreq_when_empty got=%0d exp=0", empty_pops); end
    poll();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 9; k++) begin
        bus_read(p == 0 ? 16'h4016 : 16'h4017, v);
        checks++;
        if (v !== exp_read(w2, p, k, poll_w1)) begin
          errors++; $display("FAIL b2b_snapshot pad=%0d k=%0d got=%h exp=%h", p, k, v, exp_read(w2, p, k, poll_w1));
        end
      end
  endtask

  task automatic test_capture_midread();
    logic [7:0] v;
    logic [15:0] wa, wb;
    int pa;
    wa = 16'($urandom);
    wb = ~wa;
    push_word(wa);
    settle();
    poll();
    pa = poll_w1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin push_word(wb); settle(); end
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(wa, 0, k, pa)) begin
        errors++; $display("FAIL midread k=%0d got=%h exp=%h", k, v, exp_read(wa, 0, k, pa));
      end
    end
    poll();
    for (int k = 0; k < 8; k++) begin
      bus_read(16'h4016, v);
      checks++;
      if (v !== exp_read(wb, 0, k, poll_w1)) begin
        errors++; $display("FAIL midread_next k=%0d got=%h exp=%h", k, v, exp_read(wb, 0, k, poll_w1));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [15:0] w;
    for (int n = 0; n < 8; n++) begin
      w = 16'($urandom);
      push_word(w);
      settle();
      poll();
      for (int k = 0; k < 10; k++) begin
        for (int p = 0; p < 2; p++) begin
          bus_read(p == 0 ? 16'h4016 : 16'h4017, v);
          checks++;
          if (v !== exp_read(w, p, k, poll_w1)) begin
            errors++; $display("FAIL random w=%h pad=%0d k=%0d got=%h exp=%h", w, p, k, v, exp_read(w, p, k, poll_w1));
          end
        end
      end
    end
  endtask

`ifdef JOY_TURBO_EN
  task automatic test_turbo();
    logic [7:0] v;
    logic [3:0] exp_a;
    exp_a = 4'b0011;
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    reset = 1'b1;
    w1_count = 0;
    push_word(16'hFF7F);
    settle();
    for (int i = 0; i < 4; i++) begin
      poll();
      bus_read(16'h4016, v);
      checks++;
      if (v !== {7'h20, exp_a[3 - i]}) begin
        errors++; $display("FAIL turbo poll=%0d got=%h exp=%h", i, v, {7'h20, exp_a[3 - i]});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_serial();
    test_strobe_held();
    test_back_to_back();
    test_capture_midread();
    test_random();
`ifdef JOY_TURBO_EN
    test_turbo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
